// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: line geometry and the refill FSM state encoding.
package dcache_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int IDX_BITS    = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = IDX_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD_REQ,
        RD_WAIT,
        DONE
    } refill_state_t;

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Miss handler: optional victim writeback, then a word-by-word line refill into
// the cache fill port, closed by a single fill_done pulse.
module dcache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = dcache_pkg::LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_req,
    input  logic [ADDR_WIDTH-1:0]         miss_addr,
    input  logic                          victim_dirty,
    input  logic [ADDR_WIDTH-1:0]         victim_addr,
    output logic [$clog2(LINE_WORDS)-1:0] vic_idx,
    input  logic [DATA_WIDTH-1:0]         vic_data,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_WIDTH-1:0]         fill_data,
    output logic                          fill_done,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);
    import dcache_pkg::*;

    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFF = IW + 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;

    refill_state_t         r_state, w_next;
    logic [IW-1:0]         r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_miss_base, r_vic_base;
    logic [ADDR_WIDTH-1:0] w_word_off;
    logic                  w_last;

    // Byte offset of the current word within its line; last word when all index bits set
    assign w_word_off = {{(ADDR_WIDTH-OFF){1'b0}}, r_cnt, 2'b00};
    assign w_last     = &r_cnt;

    // State and word counter; async reset drops everything back to IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture both line bases when a miss is accepted; they hold for the whole refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_base <= '0;
            r_vic_base  <= '0;
        end else if (r_state == IDLE && miss_req) begin
            r_miss_base <= miss_addr & LINE_MASK;
            r_vic_base  <= victim_addr & LINE_MASK;
        end
    end

    // Next-state and output decode; every output is zero unless its state drives it
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        vic_idx   = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        fill_done = 1'b0;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                // Dirty flag only steers this one transition, so it is not stored
                if (miss_req) begin
                    w_next    = victim_dirty ? WB : RD_REQ;
                    w_cnt_nxt = '0;
                end
            end
            WB: begin
                busy      = 1'b1;
                vic_idx   = r_cnt;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_vic_base + w_word_off;
                mem_wdata = vic_data;
                if (mem_ready) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = r_miss_base + w_word_off;
                if (mem_ready) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    fill_we   = 1'b1;
                    fill_idx  = r_cnt;
                    fill_data = mem_rdata;
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_next    = w_last ? DONE : RD_REQ;
                end
            end
            DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench: a cycle-level memory responder and cache model drive the DUT,
// and each miss is checked against a transaction-level expectation of the
// writebacks, reads and fills it must produce.
module tb_dcache_refill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          victim_dirty;
    logic [AW-1:0] victim_addr;
    logic [IW-1:0] vic_idx;
    logic [DW-1:0] vic_data;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          fill_done;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    dcache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .vic_idx(vic_idx),
        .vic_data(vic_data), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_done(fill_done), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cache victim line contents: word i holds seed ^ 0x11*(i+1)
    logic [DW-1:0] vic_seed;
    assign vic_data = vic_seed ^ (32'h11 * (32'(vic_idx) + 32'd1));

    int n_tests = 0;
    int n_fail  = 0;

    // responder knobs and state
    int            stall_min, stall_max, dly_min, dly_max, spur_pct;
    int            wcnt, stall_tgt, dly;
    bit            pend, drop_early, simple_data;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] data_salt;
    // per-miss observation
    int            cyc, first_req, last_fill, done_cyc, done_cnt;
    bit            prev_stalled;
    logic          prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [31:0]   wa_q[$], wd_q[$], ra_q[$], fi_q[$], fd_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image: word at byte address a
    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (simple_data) return 32'hA0 + ((a >> 2) % LW);
        return (a * 32'h9E37_79B9) ^ data_salt;
    endfunction

    function automatic logic outs_nonzero();
        return (vic_idx != 0) | fill_we | (fill_idx != 0) | (fill_data != 0) | fill_done |
               busy | mem_req | mem_we | (mem_addr != 0) | (mem_wdata != 0);
    endfunction

    // One clock: drive responder inputs at negedge, sample, record events
    task automatic step();
        bit spurious;
        spurious = 0;
        @(negedge clk);
        if (mem_req) mem_ready = (wcnt >= stall_tgt);
        else         mem_ready = 1'($urandom_range(0, 1));
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend && dly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_fn(pend_addr);
        end else if (!pend && !(mem_req && !mem_we && mem_ready) &&
                     $urandom_range(0, 99) < spur_pct) begin
            mem_rvalid = 1'b1;
            spurious   = 1;
        end
        #1;
        cyc++;
        if (spurious) chk("spur_no_fill", fill_we, 0);
        if (prev_stalled) begin
            chk("hold_req", {mem_req, mem_we}, {1'b1, prev_we});
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req && first_req < 0) first_req = cyc;
        if (fill_we) begin
            fi_q.push_back(32'(fill_idx));
            fd_q.push_back(fill_data);
            last_fill = cyc;
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_rvalid && !spurious) pend = 0;
        else if (pend && dly > 0) dly--;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
            end else begin
                ra_q.push_back(mem_addr);
                pend      = 1;
                pend_addr = mem_addr;
                dly       = $urandom_range(dly_min, dly_max);
            end
            wcnt      = 0;
            stall_tgt = $urandom_range(stall_min, stall_max);
        end else if (mem_req) begin
            wcnt++;
        end
        prev_stalled = mem_req && !mem_ready;
        prev_we      = mem_we;
        prev_addr    = mem_addr;
        prev_wdata   = mem_wdata;
    endtask

    task automatic clear_obs();
        wa_q.delete(); wd_q.delete(); ra_q.delete(); fi_q.delete(); fd_q.delete();
        cyc = 0; first_req = -1; last_fill = -1; done_cyc = -1; done_cnt = 0;
        wcnt = 0; stall_tgt = $urandom_range(stall_min, stall_max);
    endtask

    // Run one complete miss and compare what happened with the expected line transfer
    task automatic run_miss(input string tag, input logic [AW-1:0] ma, input logic [AW-1:0] va,
                            input bit dirty, input bit keep, input logic [AW-1:0] next_ma,
                            input bit chk_lat);
        logic [AW-1:0] mb, vb;
        int guard;
        clear_obs();
        mb = ma & ~32'(LW * 4 - 1);
        vb = va & ~32'(LW * 4 - 1);
        miss_addr = ma; victim_addr = va; victim_dirty = dirty; miss_req = 1'b1;
        guard = 0;
        while (done_cnt == 0 && guard < 600) begin
            step();
            guard++;
            if (busy && drop_early && !keep) miss_req = 1'b0;
        end
        if (done_cnt == 0) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_busy_at_done"}, busy, 1);
        if (keep) miss_addr = next_ma;
        else      miss_req  = 1'b0;
        // DONE is followed by one IDLE cycle whatever miss_req does
        step();
        chk({tag, "_idle_after_done"}, {fill_done, busy}, 2'b00);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_wr_cnt"}, wa_q.size(), dirty ? LW : 0);
        for (int i = 0; i < wa_q.size() && i < LW; i++) begin
            chk({tag, "_wr_addr"}, wa_q[i], vb + 32'(i * 4));
            chk({tag, "_wr_data"}, wd_q[i], vic_seed ^ (32'h11 * 32'(i + 1)));
        end
        chk({tag, "_rd_cnt"}, ra_q.size(), LW);
        for (int i = 0; i < ra_q.size() && i < LW; i++)
            chk({tag, "_rd_addr"}, ra_q[i], mb + 32'(i * 4));
        chk({tag, "_fill_cnt"}, fi_q.size(), LW);
        for (int i = 0; i < fi_q.size() && i < LW; i++) begin
            chk({tag, "_fill_idx"}, fi_q[i], i);
            chk({tag, "_fill_data"}, fd_q[i], rd_fn(mb + 32'(i * 4)));
        end
        if (chk_lat) begin
            chk({tag, "_latency"}, last_fill - first_req + 1, 2 * LW + (dirty ? LW : 0));
            chk({tag, "_done_after_fill"}, done_cyc, last_fill + 1);
        end
    endtask

    task automatic knobs(input int smin, input int smax, input int dmin, input int dmax,
                         input int spur);
        stall_min = smin; stall_max = smax; dly_min = dmin; dly_max = dmax; spur_pct = spur;
    endtask

    initial begin
        int guard;
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_addr = '0; victim_dirty = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; vic_seed = '0;
        data_salt = '0; simple_data = 1; drop_early = 0; pend = 0; dly = 0; prev_stalled = 0;
        knobs(0, 0, 0, 0, 0);
        clear_obs();
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs_zero", outs_nonzero(), 0);
        @(negedge clk) rst = 1'b0;

        // 1. clean miss, ideal memory
        run_miss("t1_clean", 32'h0000_1234, 32'h0, 1'b0, 1'b0, '0, 1'b1);
        // 2. dirty miss
        run_miss("t2_dirty", 32'h0000_1234, 32'h0000_8000, 1'b1, 1'b0, '0, 1'b1);
        // 3. three stall cycles on every request
        knobs(3, 3, 0, 0, 0);
        run_miss("t3_stall", 32'h0000_1234, 32'h0000_8004, 1'b1, 1'b0, '0, 1'b0);
        // 4. spurious rvalid while idle, then during requests of a stalled refill
        knobs(0, 0, 0, 0, 100);
        miss_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        knobs(2, 2, 1, 2, 100);
        run_miss("t4_spur", 32'h0000_1234, 32'h0, 1'b0, 1'b0, '0, 1'b0);

        // 5. reset while waiting for word 2 of the line
        knobs(0, 0, 3, 3, 0);
        clear_obs();
        miss_addr = 32'h0000_4440; victim_dirty = 1'b0; miss_req = 1'b1;
        guard = 0;
        while (!(ra_q.size() == 3 && pend && !mem_req) && guard < 200) begin
            step();
            guard++;
        end
        chk("t5_reached_word2", {28'(ra_q.size()), 4'(fi_q.size())}, {28'd3, 4'd2});
        rst = 1'b1;
        #1 chk("t5_rst_outputs_zero", outs_nonzero(), 0);
        miss_req = 1'b0; pend = 0; prev_stalled = 0;
        @(posedge clk);
        #1 chk("t5_rst_edge_zero", outs_nonzero(), 0);
        @(negedge clk) rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_done", done_cnt, 0);
        knobs(0, 0, 0, 0, 0);
        run_miss("t5_restart", 32'h0000_4440, 32'h0, 1'b0, 1'b0, '0, 1'b1);

        // 6. miss_req held across fill_done, second miss taken from IDLE
        run_miss("t6_first", 32'h0000_1234, 32'h0, 1'b0, 1'b1, 32'h0000_2000, 1'b1);
        run_miss("t6_second", 32'h0000_2000, 32'h0, 1'b0, 1'b0, '0, 1'b1);

        // randomized misses: addresses, dirtiness, stalls, latency, spurious rvalid, early drop
        simple_data = 0;
        for (int n = 0; n < 25; n++) begin
            data_salt  = $urandom;
            vic_seed   = $urandom;
            drop_early = 1'($urandom_range(0, 1));
            knobs(0, $urandom_range(0, 3), 0, $urandom_range(0, 3), 30);
            run_miss("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
